// File: rtl/pc_stack.sv
// Program counter with mode-selected next address and a hardware return-address
// stack. Stack overflow or underflow enters a FAULT state that freezes the PC
// and the stack until I_CLEAR_FAULT is seen at a clock edge.
module pc_stack #(
  parameter int P_ADDRESS_WIDTH = 16,
  parameter int P_STACK_DEPTH   = 8,
  parameter logic [P_ADDRESS_WIDTH-1:0] P_RESET_ADDRESS = '0
) (
  input  logic                                   I_CLK,
  input  logic                                   I_NRESET,
  input  logic                                   I_ENABLE,
  input  logic [2:0]                             I_MODE,
  input  logic [P_ADDRESS_WIDTH-1:0]             I_ADDRESS,
  input  logic                                   I_CLEAR_FAULT,
  output logic [P_ADDRESS_WIDTH-1:0]             O_ADDRESS,
  output logic [$clog2(P_STACK_DEPTH+1)-1:0]     O_STACK_DEPTH,
  output logic                                   O_STACK_EMPTY,
  output logic                                   O_STACK_FULL,
  output logic                                   O_OVERFLOW,
  output logic                                   O_UNDERFLOW,
  output logic                                   O_FAULT
);

  localparam int AW = P_ADDRESS_WIDTH;
  localparam int DW = $clog2(P_STACK_DEPTH + 1);
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
  localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(P_STACK_DEPTH);

  typedef enum logic [2:0] {
    MODE_INC      = 3'd0,
    MODE_JUMP     = 3'd1,
    MODE_JUMP_INC = 3'd2,
    MODE_DISPLACE = 3'd3,
    MODE_CALL     = 3'd4,
    MODE_RETURN   = 3'd5,
    MODE_HOLD     = 3'd6,
    MODE_RESERVED = 3'd7
  } mode_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t            state_q, state_next;
  logic [AW-1:0]     pc_q, pc_next;
  logic [DW-1:0]     depth_q, depth_next;
  logic              overflow_q, overflow_next;
  logic              underflow_q, underflow_next;
  logic              push_en;
  logic [AW-1:0]     push_data;
  logic [AW-1:0]     top_entry;
  logic              stack_empty;
  logic              stack_full;
  logic [AW-1:0]     stack_mem [P_STACK_DEPTH];
  mode_t             mode;

  assign mode        = mode_t'(I_MODE);
  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == DEPTH_FULL);

  // Select the entry just below the depth pointer as the current top of stack.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < P_STACK_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) begin
        top_entry = stack_mem[i];
      end
    end
  end

  // Next-state logic: address select, stack push/pop and RUN/FAULT transitions.
  always_comb begin
    state_next     = state_q;
    pc_next        = pc_q;
    depth_next     = depth_q;
    overflow_next  = overflow_q;
    underflow_next = underflow_q;
    push_en        = 1'b0;
    push_data      = pc_q + ADDR_ONE;

    if (state_q == ST_FAULT) begin
      // Frozen until software acknowledges; the mode is not executed on the
      // clearing edge itself.
      if (I_CLEAR_FAULT) begin
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        state_next     = ST_RUN;
      end
    end else if (I_ENABLE) begin
      case (mode)
        MODE_INC:      pc_next = pc_q + ADDR_ONE;
        MODE_JUMP:     pc_next = I_ADDRESS;
        MODE_JUMP_INC: pc_next = I_ADDRESS + ADDR_ONE;
        // Two's complement addition at full width is the signed displacement.
        MODE_DISPLACE: pc_next = pc_q + I_ADDRESS;
        MODE_CALL: begin
          if (stack_full) begin
            overflow_next = 1'b1;
            state_next    = ST_FAULT;
          end else begin
            push_en    = 1'b1;
            depth_next = depth_q + DEPTH_ONE;
            pc_next    = I_ADDRESS;
          end
        end
        MODE_RETURN: begin
          if (stack_empty) begin
            underflow_next = 1'b1;
            state_next     = ST_FAULT;
          end else begin
            pc_next    = top_entry;
            depth_next = depth_q - DEPTH_ONE;
          end
        end
        default: pc_next = pc_q;
      endcase
    end
  end

  // Control state register: PC, depth pointer, sticky flags and FSM state.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q     <= ST_RUN;
      pc_q        <= P_RESET_ADDRESS;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_next;
      pc_q        <= pc_next;
      depth_q     <= depth_next;
      overflow_q  <= overflow_next;
      underflow_q <= underflow_next;
    end
  end

  // Return-address storage; contents are don't-care after reset because the
  // depth pointer alone decides which entries are valid.
  always_ff @(posedge I_CLK) begin
    for (int i = 0; i < P_STACK_DEPTH; i++) begin
      if (push_en && (depth_q == DW'(i))) begin
        stack_mem[i] <= push_data;
      end
    end
  end

  assign O_ADDRESS     = pc_q;
  assign O_STACK_DEPTH = depth_q;
  assign O_STACK_EMPTY = stack_empty;
  assign O_STACK_FULL  = stack_full;
  assign O_OVERFLOW    = overflow_q;
  assign O_UNDERFLOW   = underflow_q;
  assign O_FAULT       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios followed by random
// stimulus, all compared against a queue-based reference model.
module tb_pc_stack;

  localparam int AW = 16;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);
  localparam logic [AW-1:0] RST_ADDR = 16'h0010;

  logic          I_CLK;
  logic          I_NRESET;
  logic          I_ENABLE;
  logic [2:0]    I_MODE;
  logic [AW-1:0] I_ADDRESS;
  logic          I_CLEAR_FAULT;
  logic [AW-1:0] O_ADDRESS;
  logic [DW-1:0] O_STACK_DEPTH;
  logic          O_STACK_EMPTY;
  logic          O_STACK_FULL;
  logic          O_OVERFLOW;
  logic          O_UNDERFLOW;
  logic          O_FAULT;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stack [$];
  bit            m_fault, m_ovf, m_unf;

  pc_stack #(
    .P_ADDRESS_WIDTH (AW),
    .P_STACK_DEPTH   (SD),
    .P_RESET_ADDRESS (RST_ADDR)
  ) dut (
    .I_CLK         (I_CLK),
    .I_NRESET      (I_NRESET),
    .I_ENABLE      (I_ENABLE),
    .I_MODE        (I_MODE),
    .I_ADDRESS     (I_ADDRESS),
    .I_CLEAR_FAULT (I_CLEAR_FAULT),
    .O_ADDRESS     (O_ADDRESS),
    .O_STACK_DEPTH (O_STACK_DEPTH),
    .O_STACK_EMPTY (O_STACK_EMPTY),
    .O_STACK_FULL  (O_STACK_FULL),
    .O_OVERFLOW    (O_OVERFLOW),
    .O_UNDERFLOW   (O_UNDERFLOW),
    .O_FAULT       (O_FAULT)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  // Guard against a stuck run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_pc = RST_ADDR;
    m_stack.delete();
    m_fault = 0;
    m_ovf   = 0;
    m_unf   = 0;
  endtask

  // One clock edge of architectural behaviour.
  task automatic modelStep(input bit en, input int mode, input logic [AW-1:0] addr,
                           input bit clr);
    if (m_fault) begin
      if (clr) begin
        m_fault = 0;
        m_ovf   = 0;
        m_unf   = 0;
      end
    end else if (en) begin
      case (mode)
        0: m_pc = m_pc + 16'd1;
        1: m_pc = addr;
        2: m_pc = addr + 16'd1;
        3: m_pc = m_pc + addr;
        4: begin
          if (m_stack.size() == SD) begin
            m_ovf   = 1;
            m_fault = 1;
          end else begin
            m_stack.push_back(m_pc + 16'd1);
            m_pc = addr;
          end
        end
        5: begin
          if (m_stack.size() == 0) begin
            m_unf   = 1;
            m_fault = 1;
          end else begin
            m_pc = m_stack.pop_back();
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic checkAll();
    checkOutput("address",   32'(O_ADDRESS),     32'(m_pc));
    checkOutput("depth",     32'(O_STACK_DEPTH), m_stack.size());
    checkOutput("empty",     32'(O_STACK_EMPTY), 32'(m_stack.size() == 0));
    checkOutput("full",      32'(O_STACK_FULL),  32'(m_stack.size() == SD));
    checkOutput("overflow",  32'(O_OVERFLOW),    32'(m_ovf));
    checkOutput("underflow", 32'(O_UNDERFLOW),   32'(m_unf));
    checkOutput("fault",     32'(O_FAULT),       32'(m_fault));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input bit en, input int mode, input logic [AW-1:0] addr,
                               input bit clr);
    I_ENABLE      = en;
    I_MODE        = 3'(mode);
    I_ADDRESS     = addr;
    I_CLEAR_FAULT = clr;
    modelStep(en, mode, addr, clr);
    @(posedge I_CLK);
    #1;
    checkAll();
  endtask

  initial begin
    I_NRESET      = 1'b0;
    I_ENABLE      = 1'b0;
    I_MODE        = 3'd6;
    I_ADDRESS     = '0;
    I_CLEAR_FAULT = 1'b0;
    modelReset();
    #12;
    I_NRESET = 1'b1;
    #1;
    checkOutput("reset_addr", 32'(O_ADDRESS), 32'h0010);
    checkAll();

    // Increment and clock-enable hold.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 16'h0, 0);
    checkOutput("inc3", 32'(O_ADDRESS), 32'h0013);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 16'h0, 0);
    checkOutput("en_hold", 32'(O_ADDRESS), 32'h0013);

    // Wrap-around arithmetic.
    applyStimulus(1, 1, 16'hFFFF, 0);
    applyStimulus(1, 0, 16'h0000, 0);
    checkOutput("inc_wrap", 32'(O_ADDRESS), 32'h0000);
    applyStimulus(1, 1, 16'h0005, 0);
    applyStimulus(1, 3, 16'hFFFC, 0);
    checkOutput("displace_neg", 32'(O_ADDRESS), 32'h0001);
    applyStimulus(1, 2, 16'h0100, 0);
    checkOutput("jump_inc", 32'(O_ADDRESS), 32'h0101);

    // Nested call/return.
    applyStimulus(1, 1, 16'h0020, 0);
    applyStimulus(1, 4, 16'h0200, 0);
    applyStimulus(1, 4, 16'h0300, 0);
    checkOutput("call2_depth", 32'(O_STACK_DEPTH), 32'd2);
    applyStimulus(1, 5, 16'h0, 0);
    checkOutput("ret1", 32'(O_ADDRESS), 32'h0201);
    applyStimulus(1, 5, 16'h0, 0);
    checkOutput("ret2", 32'(O_ADDRESS), 32'h0021);
    checkOutput("ret2_empty", 32'(O_STACK_EMPTY), 32'd1);

    // Fill the stack, overflow, ignored mode while faulted, clear.
    for (int i = 0; i < SD; i++) applyStimulus(1, 4, 16'h1000 + 16'(i), 0);
    checkOutput("full_flag", 32'(O_STACK_FULL), 32'd1);
    applyStimulus(1, 4, 16'h0400, 0);
    checkOutput("ovf_pc", 32'(O_ADDRESS), 32'h1003);
    checkOutput("ovf_flag", 32'(O_OVERFLOW), 32'd1);
    applyStimulus(1, 1, 16'h0500, 0);
    checkOutput("fault_frozen", 32'(O_ADDRESS), 32'h1003);
    applyStimulus(1, 1, 16'h0600, 1);
    checkOutput("clr_depth", 32'(O_STACK_DEPTH), 32'(SD));
    checkOutput("clr_fault", 32'(O_FAULT), 32'd0);
    for (int i = 0; i < SD; i++) applyStimulus(1, 5, 16'h0, 0);

    // Underflow and clear with enable low.
    applyStimulus(1, 1, 16'h0042, 0);
    applyStimulus(1, 5, 16'h0, 0);
    checkOutput("unf_pc", 32'(O_ADDRESS), 32'h0042);
    checkOutput("unf_flag", 32'(O_UNDERFLOW), 32'd1);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("unf_clr", 32'(O_UNDERFLOW), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 7),
                    16'($urandom()), $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset between edges at depth 3.
    applyStimulus(0, 6, 16'h0, 1);
    applyStimulus(0, 6, 16'h0, 1);
    while (m_stack.size() != 0) applyStimulus(1, 5, 16'h0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4, 16'h2000 + 16'(i), 0);
    checkOutput("pre_rst_depth", 32'(O_STACK_DEPTH), 32'd3);
    #3;
    I_NRESET = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_addr", 32'(O_ADDRESS), 32'(RST_ADDR));
    checkOutput("async_rst_depth", 32'(O_STACK_DEPTH), 32'd0);
    #2;
    I_NRESET = 1'b1;
    #1;
    applyStimulus(1, 0, 16'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
